// File: rtl/fec_pkg.sv
// Shared types and constants for the FEC frame controller and its decoder.
package fec_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DECODE  = 2'd1,
    DRAIN   = 2'd2
  } fec_ctrl_state_t;

  localparam int FEC_WIDTH_DEF = 4;
  localparam int FEC_DEPTH_DEF = 4;

  // Even parity: data XOR parity bit equals this value when the line is clean.
  localparam logic PARITY_EVEN = 1'b0;

endpackage

// File: rtl/fec_frame_ctrl_if.sv
// Input and output row streams of the FEC frame controller.
interface fec_frame_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [DEPTH-1:0] in_row_p;
  logic [WIDTH-1:0] in_col_p;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_err_det;
  logic             out_err_corr;
  logic             out_uncorr;

  // Frame source / result sink side.
  modport master (
    output in_valid, in_data, in_row_p, in_col_p, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_err_det, out_err_corr, out_uncorr
  );

  // Controller side.
  modport slave (
    input  in_valid, in_data, in_row_p, in_col_p, out_ready,
    output in_ready, out_valid, out_data, out_last, out_err_det, out_err_corr, out_uncorr
  );
endinterface

// File: rtl/cpc_fec.sv
// Combinational cross-parity-check decoder: fixes one flipped data bit located
// by a single row and a single column syndrome; a lone parity-bit error is
// reported as corrected with the data untouched; anything else is uncorrectable.
module cpc_fec
  import fec_pkg::*;
#(
  parameter int WIDTH = FEC_WIDTH_DEF,
  parameter int DEPTH = FEC_DEPTH_DEF
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] data_i,
  input  logic [DEPTH-1:0]            row_p_i,
  input  logic [WIDTH-1:0]            col_p_i,
  output logic [DEPTH-1:0][WIDTH-1:0] data_o,
  output logic                        err_det_o,
  output logic                        err_corr_o
);

  logic [DEPTH-1:0] rs;
  logic [WIDTH-1:0] cs;
  int               nr;
  int               nc;
  logic             single_bit;

  // Row/column syndromes and the single-bit fix.
  always_comb begin
    rs = '0;
    cs = '0;
    for (int r = 0; r < DEPTH; r++) begin
      rs[r] = (^data_i[r]) ^ row_p_i[r] ^ PARITY_EVEN;
    end
    for (int c = 0; c < WIDTH; c++) begin
      cs[c] = col_p_i[c] ^ PARITY_EVEN;
      for (int r = 0; r < DEPTH; r++) begin
        cs[c] = cs[c] ^ data_i[r][c];
      end
    end
    nr = $countones(rs);
    nc = $countones(cs);
    single_bit = (nr == 1) && (nc == 1);
    data_o = data_i;
    if (single_bit) begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int c = 0; c < WIDTH; c++) begin
          if (rs[r] && cs[c]) data_o[r][c] = ~data_i[r][c];
        end
      end
    end
    err_det_o  = (nr + nc) != 0;
    err_corr_o = single_bit || ((nr + nc) == 1);
  end

endmodule

// File: rtl/fec_frame_ctrl.sv
// Frame sequencer around cpc_fec: collects DEPTH rows, decodes in one cycle,
// drains the corrected rows with per-frame status, keeps saturating counters.
module fec_frame_ctrl
  import fec_pkg::*;
#(
  parameter int WIDTH = FEC_WIDTH_DEF,
  parameter int DEPTH = FEC_DEPTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fec_en,
  input  logic             stat_clr,
  fec_frame_ctrl_if.slave  bus,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  fec_ctrl_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [DEPTH-1:0][WIDTH-1:0] mat_q;
  logic [DEPTH-1:0]            rowp_q;
  logic [WIDTH-1:0]            colp_q;
  logic [DEPTH-1:0][WIDTH-1:0] omat_q;
  logic                        det_q, corr_q, unc_q;

  logic [DEPTH-1:0][WIDTH-1:0] dec_data;
  logic                        dec_det, dec_corr;

  logic [CNT_W-1:0] frame_q, frame_d, corr_q_cnt, corr_d_cnt, unc_q_cnt, unc_d_cnt;

  logic in_ready, out_valid, in_fire, out_fire, at_last, frame_done, draining;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  cpc_fec #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dec (
    .data_i    (mat_q),
    .row_p_i   (rowp_q),
    .col_p_i   (colp_q),
    .data_o    (dec_data),
    .err_det_o (dec_det),
    .err_corr_o(dec_corr)
  );

  assign at_last    = (idx_q == LAST_IDX);
  assign in_fire    = in_ready & bus.in_valid;
  assign out_fire   = out_valid & bus.out_ready;
  assign frame_done = out_fire & at_last;
  assign draining   = (state_q == DRAIN);

  // Next-state, row index and handshake readies.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          if (at_last) begin
            idx_d   = '0;
            state_d = DECODE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DECODE: state_d = DRAIN;
      DRAIN: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          if (at_last) begin
            idx_d   = '0;
            state_d = COLLECT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = COLLECT;
        idx_d   = '0;
      end
    endcase
  end

  // FSM state and row index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Input matrix capture; parities are taken with the final row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mat_q  <= '0;
      rowp_q <= '0;
      colp_q <= '0;
    end else if (in_fire) begin
      mat_q[idx_q] <= bus.in_data;
      if (at_last) begin
        rowp_q <= bus.in_row_p;
        colp_q <= bus.in_col_p;
      end
    end
  end

  // Decode result register; fec_en is looked at only in the DECODE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      omat_q <= '0;
      det_q  <= 1'b0;
      corr_q <= 1'b0;
      unc_q  <= 1'b0;
    end else if (state_q == DECODE) begin
      if (fec_en) begin
        omat_q <= dec_data;
        det_q  <= dec_det;
        corr_q <= dec_corr;
        unc_q  <= dec_det & ~dec_corr;
      end else begin
        omat_q <= mat_q;
        det_q  <= 1'b0;
        corr_q <= 1'b0;
        unc_q  <= 1'b0;
      end
    end
  end

  // Counter next values: clear has priority over a same-cycle increment.
  always_comb begin
    frame_d    = stat_clr ? '0 : sat_inc(frame_q, frame_done);
    corr_d_cnt = stat_clr ? '0 : sat_inc(corr_q_cnt, frame_done & corr_q);
    unc_d_cnt  = stat_clr ? '0 : sat_inc(unc_q_cnt, frame_done & unc_q);
  end

  // Statistics counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q    <= '0;
      corr_q_cnt <= '0;
      unc_q_cnt  <= '0;
    end else begin
      frame_q    <= frame_d;
      corr_q_cnt <= corr_d_cnt;
      unc_q_cnt  <= unc_d_cnt;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = draining ? omat_q[idx_q] : '0;
  assign bus.out_last     = draining & at_last;
  assign bus.out_err_det  = draining & det_q;
  assign bus.out_err_corr = draining & corr_q;
  assign bus.out_uncorr   = draining & unc_q;

  assign frame_cnt  = frame_q;
  assign corr_cnt   = corr_q_cnt;
  assign uncorr_cnt = unc_q_cnt;

endmodule
